// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers completed results per producer and broadcasts
// one per cycle, rotating priority round-robin, with a finish pulse back to the winner.
module cdb_arbiter #(
   parameter int unsigned NSRC     = 3,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned TAG_FREE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NSRC-1:0]         src_valid,
   input  logic [NSRC*TAG_W-1:0]   src_tag,
   input  logic [NSRC*DATA_W-1:0]  src_data,
   output logic [NSRC-1:0]         src_ready,
   output logic [NSRC-1:0]         src_finish,
   output logic                    cdb_valid,
   output logic [TAG_W-1:0]        cdb_tag,
   output logic [DATA_W-1:0]       cdb_data,
   output logic [$clog2(NSRC)-1:0] cdb_src
);

   localparam int unsigned SW = $clog2(NSRC);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [TAG_W-1:0]  tag_mem_q  [NSRC][DEPTH];
   logic [DATA_W-1:0] data_mem_q [NSRC][DEPTH];
   logic [PW-1:0]     rd_ptr_q [NSRC];
   logic [PW-1:0]     rd_ptr_d [NSRC];
   logic [PW-1:0]     wr_ptr_q [NSRC];
   logic [PW-1:0]     wr_ptr_d [NSRC];
   logic [CW-1:0]     count_q  [NSRC];
   logic [CW-1:0]     count_d  [NSRC];
   logic [SW-1:0]     rr_ptr_q;
   logic [SW-1:0]     rr_ptr_d;
   logic [NSRC-1:0]   push;
   logic [NSRC-1:0]   pop;
   logic              grant;
   logic [SW-1:0]     winner;
   logic [SW-1:0]     idx;

   // A valid carrying the reserved tag is dropped here, so it never reaches a FIFO.
   always_comb begin
      for (int unsigned i = 0; i < NSRC; i++) begin
         src_ready[i] = (count_q[i] < CW'(DEPTH));
         push[i]      = src_valid[i] && src_ready[i] &&
                        (src_tag[i*TAG_W +: TAG_W] != TAG_W'(TAG_FREE));
      end
   end

   // Arbitration looks only at registered FIFO state, so a push this cycle is not eligible yet.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         idx = SW'((32'(rr_ptr_q) + k) % NSRC);
         if (!grant && (count_q[idx] != '0)) begin
            grant  = 1'b1;
            winner = idx;
         end
      end
      pop = grant ? (NSRC'(1) << winner) : '0;
   end

   always_comb begin
      for (int unsigned i = 0; i < NSRC; i++) begin
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
         count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (!grant)
         rr_ptr_d = rr_ptr_q;
      else if (winner == SW'(NSRC - 1))
         rr_ptr_d = '0;
      else
         rr_ptr_d = winner + 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (push[i]) begin
            tag_mem_q[i][wr_ptr_q[i]]  <= src_tag[i*TAG_W +: TAG_W];
            data_mem_q[i][wr_ptr_q[i]] <= src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NSRC; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         rr_ptr_q   <= '0;
         cdb_valid  <= 1'b0;
         cdb_tag    <= TAG_W'(TAG_FREE);
         cdb_data   <= '0;
         cdb_src    <= '0;
         src_finish <= '0;
      end else begin
         for (int unsigned i = 0; i < NSRC; i++) begin
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
         rr_ptr_q   <= rr_ptr_d;
         cdb_valid  <= grant;
         src_finish <= pop;
         if (grant) begin
            cdb_tag  <= tag_mem_q[winner][rd_ptr_q[winner]];
            cdb_data <= data_mem_q[winner][rd_ptr_q[winner]];
            cdb_src  <= winner;
         end else begin
            cdb_tag  <= TAG_W'(TAG_FREE);
            cdb_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model feeding an expected-output
// scoreboard, plus directed checks on latency, ordering, fairness and reset.
module tb_cdb_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  src_valid;
   logic [11:0] src_tag;
   logic [95:0] src_data;
   logic [2:0]  src_ready;
   logic [2:0]  src_finish;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] data;
   } ent_t;

   typedef struct packed {
      logic        v;
      logic [1:0]  src;
      logic [3:0]  tag;
      logic [31:0] data;
      logic [2:0]  fin;
   } out_t;

   ent_t mq [3][$];
   out_t exp_q [$];
   int   mrr;
   int   seen_src [$];
   int   seen_tag [$];

   cdb_arbiter #(.NSRC(3), .TAG_W(4), .DATA_W(32), .DEPTH(2), .TAG_FREE(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .src_ready (src_ready),
      .src_finish(src_finish),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: winner chosen from pre-edge FIFO contents, then pop, then push.
   task automatic model_edge();
      out_t o;
      ent_t e;
      bit   acc [3];
      int   w;
      int   idx;
      if (rst) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         exp_q.delete();
         mrr = 0;
         return;
      end
      for (int i = 0; i < 3; i++)
         acc[i] = src_valid[i] && (mq[i].size() < 2) && (src_tag[i*4 +: 4] != 4'd0);
      w = -1;
      for (int k = 0; k < 3; k++) begin
         idx = (mrr + k) % 3;
         if (w < 0 && mq[idx].size() > 0) w = idx;
      end
      o = '0;
      if (w >= 0) begin
         e      = mq[w].pop_front();
         o.v    = 1'b1;
         o.src  = 2'(w);
         o.tag  = e.tag;
         o.data = e.data;
         o.fin  = 3'(1 << w);
         mrr    = (w + 1) % 3;
      end
      for (int i = 0; i < 3; i++)
         if (acc[i]) mq[i].push_back({src_tag[i*4 +: 4], src_data[i*32 +: 32]});
      exp_q.push_back(o);
   endtask

   task automatic monitor();
      out_t       o;
      logic [2:0] mr;
      if (rst) begin
         chk("rst_valid", cdb_valid, 0);
         chk("rst_tag", cdb_tag, 0);
         chk("rst_finish", src_finish, 0);
         return;
      end
      for (int i = 0; i < 3; i++) mr[i] = (mq[i].size() < 2);
      chk("src_ready", src_ready, mr);
      if (exp_q.size() == 0) begin
         chk("model_entry", exp_q.size(), 1);
         return;
      end
      o = exp_q.pop_front();
      chk("cdb_valid", cdb_valid, o.v);
      chk("cdb_tag", cdb_tag, o.tag);
      chk("cdb_data", cdb_data, o.data);
      chk("src_finish", src_finish, o.fin);
      if (o.v) chk("cdb_src", cdb_src, o.src);
      if (cdb_valid === 1'b1) begin
         seen_src.push_back(int'(cdb_src));
         seen_tag.push_back(int'(cdb_tag));
      end
   endtask

   always @(posedge clk or posedge rst) model_edge();
   always @(negedge clk) monitor();

   task automatic drive(input int s, input logic [3:0] t, input logic [31:0] d);
      src_valid[s]       = 1'b1;
      src_tag[s*4 +: 4]  = t;
      src_data[s*32 +: 32] = d;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      src_valid = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      seen_src.delete();
      seen_tag.delete();
      chk("ready_after_rst", src_ready, 3'b111);
   endtask

   // Two producers each offer a run of results, holding each one until accepted.
   task automatic feed(input int sa, input int na, input int ta,
                       input int sb, input int nb, input int tb, input bit bp);
      int         ia;
      int         ib;
      logic [2:0] r;
      ia = 0;
      ib = 0;
      for (int c = 0; c < 40 && (ia < na || ib < nb); c++) begin
         r = src_ready;
         src_valid = '0;
         if (ia < na) drive(sa, 4'(ta + ia), 32'h1000 + 32'(ta + ia));
         if (ib < nb) drive(sb, 4'(tb + ib), 32'h2000 + 32'(tb + ib));
         if (bp && c == 2) chk("bp_ready_low", r[sb], 0);
         if (bp && c == 3) chk("bp_ready_back", r[sb], 1);
         @(negedge clk);
         if (ia < na && r[sa]) ia++;
         if (ib < nb && r[sb]) ib++;
      end
      src_valid = '0;
      chk("feed_done", ia + ib, na + nb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int s1_tags [$];
      int exp_fair [8];
      rst       = 1'b1;
      src_valid = '0;
      src_tag   = '0;
      src_data  = '0;
      do_reset();

      // Single result: accepted at edge 1, broadcast after edge 2.
      drive(0, 4'd5, 32'h0000_0010);
      @(negedge clk);
      src_valid = '0;
      chk("t1_not_yet", cdb_valid, 0);
      @(negedge clk);
      chk("t1_valid", cdb_valid, 1);
      chk("t1_tag", cdb_tag, 5);
      chk("t1_data", cdb_data, 32'h10);
      chk("t1_src", cdb_src, 0);
      chk("t1_finish", src_finish, 3'b001);
      @(negedge clk);
      chk("t1_idle_valid", cdb_valid, 0);
      chk("t1_idle_finish", src_finish, 0);

      // Simultaneous push from all three, then rr_ptr back at 0.
      do_reset();
      drive(0, 4'd1, 32'h101);
      drive(1, 4'd2, 32'h102);
      drive(2, 4'd3, 32'h103);
      @(negedge clk);
      src_valid = '0;
      tick(4);
      #1;
      chk("t2_count", seen_tag.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t2_tag", seen_tag[i], i + 1);
         chk("t2_src", seen_src[i], i);
      end
      drive(0, 4'd6, 32'h106);
      drive(2, 4'd7, 32'h107);
      @(negedge clk);
      src_valid = '0;
      tick(4);
      #1;
      chk("t2_rr_first", seen_tag[3], 6);
      chk("t2_rr_second", seen_tag[4], 7);

      // Backpressure on source 1 while source 0 keeps its FIFO busy.
      do_reset();
      feed(0, 4, 10, 1, 3, 7, 1'b1);
      tick(10);
      #1;
      for (int i = 0; i < seen_src.size(); i++)
         if (seen_src[i] == 1) s1_tags.push_back(seen_tag[i]);
      chk("bp_s1_count", s1_tags.size(), 3);
      for (int i = 0; i < s1_tags.size() && i < 3; i++)
         chk("bp_s1_order", s1_tags[i], 7 + i);
      chk("bp_total", seen_src.size(), 7);

      // Fairness between sources 0 and 2.
      do_reset();
      feed(0, 4, 1, 2, 4, 5, 1'b0);
      tick(6);
      #1;
      exp_fair = '{0, 2, 0, 2, 0, 2, 0, 2};
      chk("fair_count", seen_src.size(), 8);
      for (int i = 0; i < 8 && i < seen_src.size(); i++)
         chk("fair_src", seen_src[i], exp_fair[i]);

      // Reserved tag is silently dropped.
      do_reset();
      drive(2, 4'd0, 32'hDEAD_BEEF);
      tick(2);
      src_valid = '0;
      tick(3);
      #1;
      chk("free_valid", cdb_valid, 0);
      chk("free_finish", src_finish, 0);
      chk("free_none", seen_src.size(), 0);

      // Asynchronous reset in the middle of a broadcast.
      do_reset();
      drive(0, 4'd1, 32'h201);
      drive(1, 4'd2, 32'h202);
      drive(2, 4'd3, 32'h203);
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      #1;
      chk("mid_busy", cdb_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", cdb_valid, 0);
      chk("mid_rst_tag", cdb_tag, 0);
      chk("mid_rst_finish", src_finish, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      seen_src.delete();
      seen_tag.delete();
      tick(6);
      #1;
      chk("mid_no_replay", seen_src.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
